line_clear_ctrl: RTL and testbench

Sequencer that removes completed rows from the playfield after a piece locks. It is started by the game logic and owns the board memory's row read/write ports for the duration of the sweep. In one bottom-to-top pass it compacts all non-full rows downward and zero-fills the vacated top rows. It reports the number of lines removed and keeps a running total for scoring and display.

---
 rtl/tetris_pkg.sv | 25 ++
 rtl/line_clear_ctrl_if.sv | 30 +++
 rtl/line_clear_ctrl.sv | 115 +++++++++++
 tb/tb_line_clear_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield types and constants for the board-side sequencers.
// Holds the board geometry, row types, the line-clear state encoding and a saturating adder.
package tetris_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;

  typedef logic [BOARD_COLS-1:0] row_t;
  typedef logic [4:0]            row_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } lc_state_t;

  // Score counter add that pins at all ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {14'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/line_clear_ctrl_if.sv
// Game-logic handshake plus board row read/write ports of the line-clear sequencer.
// master = the sequencer, slave = game logic / board memory side.
interface line_clear_ctrl_if
  import tetris_pkg::*;
#(
  parameter int COLS = BOARD_COLS
) ();

  logic            start;
  row_idx_t        rd_row;
  logic [COLS-1:0] rd_data;
  logic            wr_en;
  row_idx_t        wr_row;
  logic [COLS-1:0] wr_data;
  logic            busy;
  logic            done;
  logic [2:0]      lines_cleared;
  logic [15:0]     total_lines;

  modport master (
    input  start, rd_data,
    output rd_row, wr_en, wr_row, wr_data, busy, done, lines_cleared, total_lines
  );

  modport slave (
    output start, rd_data,
    input  rd_row, wr_en, wr_row, wr_data, busy, done, lines_cleared, total_lines
  );

endinterface

// File: rtl/line_clear_ctrl.sv
// Bottom-to-top sweep that drops full rows, compacts the rest downward and zero-fills the top.
// Reports lines removed by the last sweep and a saturating running total.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS = BOARD_ROWS,
  parameter int COLS = BOARD_COLS
) (
  input  logic              clk,
  input  logic              reset_n,
  line_clear_ctrl_if.master bus
);

  localparam row_idx_t LAST_ROW = row_idx_t'(ROWS - 1);

  lc_state_t   r_state;
  row_idx_t    r_rd_ptr;
  row_idx_t    r_wr_ptr;
  logic [2:0]  r_cnt;
  logic [2:0]  r_fill;
  logic [2:0]  r_lines_cleared;
  logic [15:0] r_total_lines;

  logic       w_full;
  logic [2:0] w_cnt_scan;

  assign w_full     = &bus.rd_data;
  assign w_cnt_scan = (w_full && (r_cnt != 3'd7)) ? r_cnt + 3'd1 : r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_rd_ptr        <= LAST_ROW;
      r_wr_ptr        <= LAST_ROW;
      r_cnt           <= 3'd0;
      r_fill          <= 3'd0;
      r_lines_cleared <= 3'd0;
      r_total_lines   <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state         <= SCAN;
            r_rd_ptr        <= LAST_ROW;
            r_wr_ptr        <= LAST_ROW;
            r_cnt           <= 3'd0;
            r_lines_cleared <= 3'd0;
          end
        end
        SCAN: begin
          r_rd_ptr <= r_rd_ptr - 5'd1;
          r_cnt    <= w_cnt_scan;
          if (!w_full) begin
            r_wr_ptr <= r_wr_ptr - 5'd1;
          end
          // Row 0 is the last one read; the decision uses the count including it.
          if (r_rd_ptr == 5'd0) begin
            r_fill <= w_cnt_scan;
            if (w_cnt_scan != 3'd0) begin
              r_state <= FILL;
            end else begin
              r_state         <= DONE;
              r_lines_cleared <= w_cnt_scan;
              r_total_lines   <= sat_add16(r_total_lines, w_cnt_scan);
            end
          end
        end
        FILL: begin
          r_wr_ptr <= r_wr_ptr - 5'd1;
          r_fill   <= r_fill - 3'd1;
          if (r_fill == 3'd1) begin
            r_state         <= DONE;
            r_lines_cleared <= r_cnt;
            r_total_lines   <= sat_add16(r_total_lines, r_cnt);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Kept apart from the write decode: rd_data is a combinational function of rd_row.
  assign bus.rd_row        = (r_state == SCAN) ? r_rd_ptr : LAST_ROW;
  assign bus.lines_cleared = r_lines_cleared;
  assign bus.total_lines   = r_total_lines;

  always_comb begin
    bus.wr_en   = 1'b0;
    bus.wr_row  = LAST_ROW;
    bus.wr_data = '0;
    bus.busy    = (r_state == SCAN) || (r_state == FILL);
    bus.done    = (r_state == DONE);
    case (r_state)
      SCAN: begin
        bus.wr_en   = !w_full && (r_wr_ptr != r_rd_ptr);
        bus.wr_row  = r_wr_ptr;
        bus.wr_data = bus.rd_data;
      end
      FILL: begin
        bus.wr_en   = 1'b1;
        bus.wr_row  = r_wr_ptr;
        bus.wr_data = '0;
      end
      default: begin
        bus.wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: a board model answers reads, a scoreboard of expected
// writes is built from each board image before start, and every cycle of the sweep is checked.
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  localparam int ROWS = 20;
  localparam int COLS = 10;

  typedef struct {
    int              cyc;
    int              row;
    logic [COLS-1:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #10 clk = ~clk;

  line_clear_ctrl_if #(.COLS(COLS)) bus ();

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [COLS-1:0] board     [ROWS];
  logic [COLS-1:0] img       [ROWS];
  logic [COLS-1:0] exp_board [ROWS];
  logic            load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int r = 0; r < ROWS; r++) board[r] <= img[r];
    end else if (bus.wr_en && (int'(bus.wr_row) < ROWS)) begin
      board[bus.wr_row] <= bus.wr_data;
    end
  end

  assign bus.rd_data = (int'(bus.rd_row) < ROWS) ? board[bus.rd_row] : '0;

  wr_exp_t     exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_total = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int r = 0; r < ROWS; r++) img[r] = '0;
  endtask

  task automatic load_board();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Expected write stream (cycle offset from the accepting edge), final board and line count.
  task automatic plan_sweep(output int n);
    wr_exp_t e;
    int      w;
    exp_q.delete();
    n = 0;
    w = ROWS - 1;
    for (int r = 0; r < ROWS; r++) exp_board[r] = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (&img[r]) begin
        n++;
      end else begin
        exp_board[w] = img[r];
        if (w != r) begin
          e.cyc = ROWS - r; e.row = w; e.data = img[r];
          exp_q.push_back(e);
        end
        w--;
      end
    end
    for (int j = 1; j <= n; j++) begin
      e.cyc = ROWS + j; e.row = n - j; e.data = '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, " busy"},          32'(bus.busy),          32'd0);
    check({name, " done"},          32'(bus.done),          32'd0);
    check({name, " wr_en"},         32'(bus.wr_en),         32'd0);
    check({name, " lines_cleared"}, 32'(bus.lines_cleared), 32'd0);
    check({name, " total_lines"},   32'(bus.total_lines),   32'd0);
    check({name, " rd_row"},        32'(bus.rd_row),        32'(ROWS - 1));
    check({name, " wr_row"},        32'(bus.wr_row),        32'(ROWS - 1));
    check({name, " wr_data"},       32'(bus.wr_data),       32'd0);
  endtask

  task automatic run_sweep(input string name, input bit repulse);
    int          n;
    int          last;
    wr_exp_t     e;
    logic [15:0] prev_total;
    plan_sweep(n);
    load_board();
    prev_total  = model_total;
    model_total = (int'(model_total) + n > 16'hFFFF) ? 16'hFFFF : model_total + 16'(n);
    last        = ROWS + n + 3;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      bus.start = repulse && (cyc == 5 || cyc == ROWS + 1);
      check($sformatf("%s c%0d busy", name, cyc), 32'(bus.busy), 32'(cyc <= ROWS + n));
      check($sformatf("%s c%0d done", name, cyc), 32'(bus.done), 32'(cyc == ROWS + n + 1));
      if (cyc <= ROWS)
        check($sformatf("%s c%0d rd_row", name, cyc), 32'(bus.rd_row), 32'(ROWS - cyc));
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check($sformatf("%s c%0d wr_en", name, cyc),   32'(bus.wr_en),   32'd1);
        check($sformatf("%s c%0d wr_row", name, cyc),  32'(bus.wr_row),  32'(e.row));
        check($sformatf("%s c%0d wr_data", name, cyc), 32'(bus.wr_data), 32'(e.data));
      end else begin
        check($sformatf("%s c%0d wr_en", name, cyc), 32'(bus.wr_en), 32'd0);
      end
      if (cyc <= ROWS + n) begin
        check($sformatf("%s c%0d lines_cleared", name, cyc), 32'(bus.lines_cleared), 32'd0);
        check($sformatf("%s c%0d total_lines", name, cyc),   32'(bus.total_lines),   32'(prev_total));
      end else begin
        check($sformatf("%s c%0d lines_cleared", name, cyc), 32'(bus.lines_cleared), 32'(n));
        check($sformatf("%s c%0d total_lines", name, cyc),   32'(bus.total_lines),   32'(model_total));
      end
    end
    check($sformatf("%s writes_left", name), 32'(exp_q.size()), 32'd0);
    for (int r = 0; r < ROWS; r++)
      check($sformatf("%s board[%0d]", name, r), 32'(board[r]), 32'(exp_board[r]));
    $display("sweep %s: %0d lines, total %0d", name, n, model_total);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    load_req  = 1'b0;
    clear_img();
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset_n = 1'b1;
    @(negedge clk);

    clear_img();
    run_sweep("empty", 1'b0);

    clear_img();
    img[19] = '1; img[18] = 10'h155;
    run_sweep("one_line", 1'b0);

    clear_img();
    for (int r = 16; r <= 19; r++) img[r] = '1;
    img[15] = 10'h001;
    run_sweep("tetris", 1'b0);

    clear_img();
    img[19] = '1; img[17] = '1; img[18] = 10'h0F0; img[16] = 10'h00F;
    img[10] = 10'h2AA; img[0] = 10'h3FE;
    run_sweep("split_two", 1'b0);

    for (int r = 0; r < ROWS; r++) img[r] = COLS'($urandom_range(0, 1022));
    img[3] = '1; img[12] = '1;
    run_sweep("repulse", 1'b1);

    force dut.r_total_lines = 16'hFFFE;
    @(negedge clk);
    release dut.r_total_lines;
    model_total = 16'hFFFE;
    clear_img();
    for (int r = 16; r <= 19; r++) img[r] = '1;
    img[2] = 10'h0C3;
    run_sweep("saturate", 1'b0);

    clear_img();
    img[19] = '1; img[18] = 10'h111;
    load_board();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    $display("reset applied mid-sweep at cycle T+10");
    @(negedge clk);
    reset_n = 1'b1;
    model_total = 16'd0;
    @(negedge clk);

    clear_img();
    img[19] = 10'h3F0; img[14] = '1; img[13] = 10'h00C;
    run_sweep("after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
